// File: rtl/datapath_seq.sv
// datapath_seq: Mini-SRC shared-bus datapath with an iterative signed multiply/divide ALU.
// Define DATAPATH_DIV_EN to build the iterative divider for ALU op 9.
module datapath_seq #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned IMM_W    = 19,
   parameter int unsigned PC_STEP  = 1
) (
   input  logic                        clk,
   input  logic                        in_clr_n,
   input  logic [3:0]                  in_bus_src,
   input  logic [$clog2(NUM_REGS)-1:0] in_reg_sel,
   input  logic                        in_regfile_write,
   input  logic                        in_hi_write,
   input  logic                        in_lo_write,
   input  logic                        in_y_write,
   input  logic                        in_ir_write,
   input  logic                        in_mar_write,
   input  logic                        in_pc_write,
   input  logic                        in_mdr_write,
   input  logic                        in_inc_pc,
   input  logic                        in_mdr_select,
   input  logic [DATA_W-1:0]           in_mem_data,
   input  logic [DATA_W-1:0]           in_inport_data,
   input  logic [3:0]                  in_alu_op,
   input  logic                        in_alu_start,
   output logic                        out_alu_busy,
   output logic                        out_alu_done,
   output logic [DATA_W-1:0]           out_bus,
   output logic [DATA_W-1:0]           out_mar,
   output logic [DATA_W-1:0]           out_ir,
   output logic                        out_bus_err
);
   localparam int unsigned RW = $clog2(NUM_REGS);
   localparam int unsigned SW = $clog2(DATA_W);

   typedef enum logic [3:0] {
      SRC_ZERO, SRC_REG, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO,
      SRC_PC, SRC_MDR, SRC_INPORT, SRC_IMM
   } bus_src_e;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_NEG, OP_NOT, OP_MUL, OP_DIV
   } alu_op_e;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [DATA_W-1:0]   hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q;
   logic [DATA_W-1:0]   pc_d, mdr_d;
   logic [2*DATA_W-1:0] z_q;
   logic [DATA_W-1:0]   bus;
   logic                bus_err;

   state_e              state_q;
   logic                busy_q, done_q, neg_q;
   logic [SW-1:0]       cnt_q;
   logic [DATA_W:0]     acc_q, acc_d, mul_sum;
   logic [DATA_W-1:0]   wa_q, wa_d, wb_q;
   logic [2*DATA_W-1:0] mag_d, z_fin;
   logic [DATA_W-1:0]   single_res;
   logic [2*DATA_W-1:0] single_z;
   logic [DATA_W-1:0]   abs_y, abs_b;
   logic                start_multi;
`ifdef DATAPATH_DIV_EN
   logic                div_q, rneg_q;
   logic [DATA_W-1:0]   a_q, quot, rem;
   logic [DATA_W:0]     div_sh;
`endif

   always_comb begin
      bus     = '0;
      bus_err = 1'b0;
      case (bus_src_e'(in_bus_src))
         SRC_ZERO:   bus = '0;
         SRC_REG:    bus = rf_q[in_reg_sel];
         SRC_HI:     bus = hi_q;
         SRC_LO:     bus = lo_q;
         SRC_ZHI:    bus = z_q[2*DATA_W-1:DATA_W];
         SRC_ZLO:    bus = z_q[DATA_W-1:0];
         SRC_PC:     bus = pc_q;
         SRC_MDR:    bus = mdr_q;
         SRC_INPORT: bus = in_inport_data;
         SRC_IMM:    bus = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
         default:    bus_err = 1'b1;
      endcase
   end

   assign pc_d  = in_inc_pc ? pc_q + DATA_W'(PC_STEP) : bus;
   assign mdr_d = in_mdr_select ? in_mem_data : bus;

   always_ff @(posedge clk) begin
      if (!in_clr_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[RW'(i)] <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         y_q   <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
      end else begin
         if (in_regfile_write) rf_q[in_reg_sel] <= bus;
         if (in_hi_write)      hi_q  <= bus;
         if (in_lo_write)      lo_q  <= bus;
         if (in_y_write)       y_q   <= bus;
         if (in_ir_write)      ir_q  <= bus;
         if (in_mar_write)     mar_q <= bus;
         if (in_pc_write)      pc_q  <= pc_d;
         if (in_mdr_write)     mdr_q <= mdr_d;
      end
   end

   always_comb begin
      single_res = '0;
      case (alu_op_e'(in_alu_op))
         OP_ADD:  single_res = y_q + bus;
         OP_SUB:  single_res = y_q - bus;
         OP_AND:  single_res = y_q & bus;
         OP_OR:   single_res = y_q | bus;
         OP_SHR:  single_res = y_q >> bus[SW-1:0];
         OP_SHL:  single_res = y_q << bus[SW-1:0];
         OP_NEG:  single_res = -bus;
         OP_NOT:  single_res = ~bus;
         default: single_res = '0;
      endcase
      single_z = {{DATA_W{single_res[DATA_W-1]}}, single_res};
   end

   assign abs_y = y_q[DATA_W-1] ? -y_q : y_q;
   assign abs_b = bus[DATA_W-1] ? -bus : bus;
`ifdef DATAPATH_DIV_EN
   assign start_multi = (in_alu_op == OP_MUL) || (in_alu_op == OP_DIV);
`else
   assign start_multi = (in_alu_op == OP_MUL);
`endif

   // Both iterations work on magnitudes; signs are applied once when Z is written.
   always_comb begin
      mul_sum = acc_q + (wa_q[0] ? {1'b0, wb_q} : '0);
      acc_d   = {1'b0, mul_sum[DATA_W:1]};
      wa_d    = {mul_sum[0], wa_q[DATA_W-1:1]};
      mag_d   = {acc_d[DATA_W-1:0], wa_d};
      z_fin   = neg_q ? -mag_d : mag_d;
`ifdef DATAPATH_DIV_EN
      div_sh = {acc_q[DATA_W-1:0], wa_q[DATA_W-1]};
      quot   = '0;
      rem    = '0;
      if (div_q) begin
         if (div_sh >= {1'b0, wb_q}) begin
            acc_d = div_sh - {1'b0, wb_q};
            wa_d  = {wa_q[DATA_W-2:0], 1'b1};
         end else begin
            acc_d = div_sh;
            wa_d  = {wa_q[DATA_W-2:0], 1'b0};
         end
         quot = wa_d;
         rem  = acc_d[DATA_W-1:0];
         if (wb_q == '0) z_fin = {a_q, {DATA_W{1'b1}}};
         else            z_fin = {rneg_q ? -rem : rem, neg_q ? -quot : quot};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!in_clr_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         z_q     <= '0;
         acc_q   <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
         neg_q   <= 1'b0;
`ifdef DATAPATH_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
         a_q     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               if (in_alu_start) begin
                  if (start_multi) begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                     acc_q   <= '0;
                     neg_q   <= y_q[DATA_W-1] ^ bus[DATA_W-1];
                     wa_q    <= abs_b;
                     wb_q    <= abs_y;
`ifdef DATAPATH_DIV_EN
                     div_q   <= (in_alu_op == OP_DIV);
                     rneg_q  <= y_q[DATA_W-1];
                     a_q     <= y_q;
                     if (in_alu_op == OP_DIV) begin
                        wa_q <= abs_y;
                        wb_q <= abs_b;
                     end
`endif
                  end else begin
                     z_q     <= single_z;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               wa_q  <= wa_d;
               cnt_q <= cnt_q + SW'(1);
               if (cnt_q == SW'(DATA_W-1)) begin
                  z_q     <= z_fin;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_alu_busy = busy_q;
   assign out_alu_done = done_q;
   assign out_bus      = bus;
   assign out_bus_err  = bus_err;
   assign out_mar      = mar_q;
   assign out_ir       = ir_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_datapath_seq;
   localparam int W    = 32;
   localparam int NR   = 16;
   localparam int IW   = 19;
   localparam int STEP = 1;
`ifdef DATAPATH_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         in_clr_n, in_regfile_write, in_hi_write, in_lo_write, in_y_write;
   logic         in_ir_write, in_mar_write, in_pc_write, in_mdr_write, in_inc_pc, in_mdr_select;
   logic         in_alu_start;
   logic [3:0]   in_bus_src, in_alu_op, in_reg_sel;
   logic [W-1:0] in_mem_data, in_inport_data;
   logic         out_alu_busy, out_alu_done, out_bus_err;
   logic [W-1:0] out_bus, out_mar, out_ir;

   datapath_seq #(.DATA_W(W), .NUM_REGS(NR), .IMM_W(IW), .PC_STEP(STEP)) dut (
      .clk(clk), .in_clr_n(in_clr_n), .in_bus_src(in_bus_src), .in_reg_sel(in_reg_sel),
      .in_regfile_write(in_regfile_write), .in_hi_write(in_hi_write), .in_lo_write(in_lo_write),
      .in_y_write(in_y_write), .in_ir_write(in_ir_write), .in_mar_write(in_mar_write),
      .in_pc_write(in_pc_write), .in_mdr_write(in_mdr_write), .in_inc_pc(in_inc_pc),
      .in_mdr_select(in_mdr_select), .in_mem_data(in_mem_data), .in_inport_data(in_inport_data),
      .in_alu_op(in_alu_op), .in_alu_start(in_alu_start), .out_alu_busy(out_alu_busy),
      .out_alu_done(out_alu_done), .out_bus(out_bus), .out_mar(out_mar), .out_ir(out_ir),
      .out_bus_err(out_bus_err)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [W-1:0]   m_r [NR];
   logic [W-1:0]   m_hi = '0, m_lo = '0, m_y = '0, m_pc = '0, m_ir = '0, m_mar = '0, m_mdr = '0;
   logic [2*W-1:0] m_z = '0, m_pend = '0;
   int             m_busy_left = 0;
   bit             m_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] m_bus();
      case (in_bus_src)
         4'd1:    return m_r[in_reg_sel];
         4'd2:    return m_hi;
         4'd3:    return m_lo;
         4'd4:    return m_z[2*W-1:W];
         4'd5:    return m_z[W-1:0];
         4'd6:    return m_pc;
         4'd7:    return m_mdr;
         4'd8:    return in_inport_data;
         4'd9:    return W'($signed(m_ir[IW-1:0]));
         default: return '0;
      endcase
   endfunction

   function automatic logic [2*W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [W-1:0] r;
      longint sa, sb, q, rm;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      if (op == 4'd8) return 64'(sa * sb);
      if (op == 4'd9) begin
         if (!DIV_EN) return '0;
         if (b == '0) return {a, {W{1'b1}}};
         q  = sa / sb;
         rm = sa % sb;
         return {rm[W-1:0], q[W-1:0]};
      end
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a >> b[$clog2(W)-1:0];
         4'd5:    r = a << b[$clog2(W)-1:0];
         4'd6:    r = -b;
         4'd7:    r = ~b;
         default: return '0;
      endcase
      return {{W{r[W-1]}}, r};
   endfunction

   task automatic model_edge();
      logic [W-1:0] b;
      bit dn;
      if (!in_clr_n) begin
         foreach (m_r[i]) m_r[i] = '0;
         m_hi = '0; m_lo = '0; m_y = '0; m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0;
         m_z = '0; m_busy_left = 0; m_done = 1'b0;
         return;
      end
      b  = m_bus();
      dn = 1'b0;
      if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            m_z = m_pend;
            dn  = 1'b1;
         end
      end else if (in_alu_start) begin
         if (in_alu_op == 4'd8 || (DIV_EN && in_alu_op == 4'd9)) begin
            m_pend      = ref_alu(in_alu_op, m_y, b);
            m_busy_left = W;
         end else begin
            m_z = ref_alu(in_alu_op, m_y, b);
            dn  = 1'b1;
         end
      end
      m_done = dn;
      if (in_regfile_write) m_r[in_reg_sel] = b;
      if (in_hi_write)  m_hi  = b;
      if (in_lo_write)  m_lo  = b;
      if (in_y_write)   m_y   = b;
      if (in_ir_write)  m_ir  = b;
      if (in_mar_write) m_mar = b;
      if (in_pc_write)  m_pc  = in_inc_pc ? W'(m_pc + W'(STEP)) : b;
      if (in_mdr_write) m_mdr = in_mdr_select ? in_mem_data : b;
   endtask

   task automatic compare();
      chk("bus", out_bus, m_bus());
      chk("bus_err", out_bus_err, in_bus_src >= 4'd10);
      chk("mar", out_mar, m_mar);
      chk("ir", out_ir, m_ir);
      chk("busy", out_alu_busy, m_busy_left > 0);
      chk("done", out_alu_done, m_done);
   endtask

   task automatic step();
      #1 compare();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      in_clr_n = 1'b1;
      {in_regfile_write, in_hi_write, in_lo_write, in_y_write} = '0;
      {in_ir_write, in_mar_write, in_pc_write, in_mdr_write} = '0;
      in_inc_pc = 1'b0; in_mdr_select = 1'b0; in_alu_start = 1'b0;
      in_bus_src = '0; in_reg_sel = '0; in_alu_op = '0;
   endtask

   task automatic put_reg(input logic [3:0] sel, input logic [W-1:0] val);
      idle(); in_bus_src = 4'd8; in_inport_data = val; in_reg_sel = sel; in_regfile_write = 1'b1;
      step();
   endtask

   task automatic rd(input logic [3:0] src, input logic [3:0] sel, input string name,
                     input logic [W-1:0] exp);
      idle(); in_bus_src = src; in_reg_sel = sel;
      #1 chk(name, out_bus, exp);
      step();
   endtask

   task automatic alu_run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit seen;
      seen = 1'b0;
      idle(); in_bus_src = 4'd8; in_inport_data = a; in_y_write = 1'b1; step();
      idle(); in_bus_src = 4'd8; in_inport_data = b; in_alu_op = op; in_alu_start = 1'b1; step();
      for (int i = 0; i < 40 && !seen; i++) begin
         idle();
         #1 seen = out_alu_done;
         step();
      end
      chk("alu_done_timeout", seen, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      foreach (m_r[i]) m_r[i] = '0;
      in_mem_data = '0; in_inport_data = '0;
      idle(); in_clr_n = 1'b0;
      repeat (2) begin
         @(posedge clk); model_edge(); @(negedge clk);
      end

      idle(); in_bus_src = 4'd6;
      #1 chk("rst_pc", out_bus, 0);
      chk("rst_busy", out_alu_busy, 0);
      chk("rst_done", out_alu_done, 0);
      chk("rst_mar", out_mar, 0);
      chk("rst_ir", out_ir, 0);
      step();

      put_reg(4'd2, 32'h22);
      put_reg(4'd4, 32'h24);
      idle(); in_bus_src = 4'd1; in_reg_sel = 4'd2; in_y_write = 1'b1; step();
      idle(); in_bus_src = 4'd1; in_reg_sel = 4'd4; in_alu_op = 4'd2; in_alu_start = 1'b1; step();
      idle();
      #1 chk("and_done", out_alu_done, 1);
      step();
      idle(); in_bus_src = 4'd5; in_reg_sel = 4'd5; in_regfile_write = 1'b1; step();
      rd(4'd1, 4'd5, "and_r5", 32'h20);

      idle(); in_bus_src = 4'd8; in_inport_data = 32'hFFFF_FFFD; in_y_write = 1'b1; step();
      idle(); in_bus_src = 4'd8; in_inport_data = 32'd7; in_alu_op = 4'd8; in_alu_start = 1'b1; step();
      for (int k = 1; k <= 32; k++) begin
         idle();
         if (k == 5) begin
            in_bus_src = 4'd8; in_alu_op = 4'd0; in_alu_start = 1'b1;
         end
         #1 chk("mul_busy", out_alu_busy, 1);
         step();
      end
      idle();
      #1 chk("mul_done33", out_alu_done, 1);
      chk("mul_idle33", out_alu_busy, 0);
      step();
      rd(4'd4, 4'd0, "mul_hi", 32'hFFFF_FFFF);
      rd(4'd5, 4'd0, "mul_lo", 32'hFFFF_FFEB);

`ifdef DATAPATH_DIV_EN
      alu_run(4'd9, 32'd100, 32'd7);
      rd(4'd5, 4'd0, "div_q", 32'd14);
      rd(4'd4, 4'd0, "div_r", 32'd2);
      alu_run(4'd9, 32'hFFFF_FF9C, 32'd7);
      rd(4'd5, 4'd0, "div_nq", 32'hFFFF_FFF2);
      rd(4'd4, 4'd0, "div_nr", 32'hFFFF_FFFE);
      alu_run(4'd9, 32'd5, 32'd0);
      rd(4'd5, 4'd0, "div0_q", 32'hFFFF_FFFF);
      rd(4'd4, 4'd0, "div0_r", 32'd5);
`else
      alu_run(4'd9, 32'd100, 32'd7);
      rd(4'd5, 4'd0, "nodiv_lo", 32'd0);
      rd(4'd4, 4'd0, "nodiv_hi", 32'd0);
`endif

      idle(); in_clr_n = 1'b0; step();
      repeat (2) begin
         idle(); in_pc_write = 1'b1; in_inc_pc = 1'b1; step();
      end
      rd(4'd6, 4'd0, "pc_two_inc", 32'd2);
      idle(); in_bus_src = 4'd8; in_inport_data = 32'hFFFF_FFFF; in_pc_write = 1'b1; step();
      idle(); in_pc_write = 1'b1; in_inc_pc = 1'b1; step();
      rd(4'd6, 4'd0, "pc_wrap", 32'd0);

      idle(); in_bus_src = 4'd8; in_inport_data = 32'h0004_0000; in_ir_write = 1'b1; step();
      rd(4'd9, 4'd0, "imm_sext", 32'hFFFC_0000);
      idle(); in_bus_src = 4'd12;
      #1 chk("src12_bus", out_bus, 0);
      chk("src12_err", out_bus_err, 1);
      step();
      idle(); in_mdr_write = 1'b1; in_mdr_select = 1'b1; in_mem_data = 32'hCAFE_0001; step();
      rd(4'd7, 4'd0, "mdr_mem", 32'hCAFE_0001);

      idle(); in_bus_src = 4'd8; in_inport_data = 32'd9; in_y_write = 1'b1; step();
      idle(); in_bus_src = 4'd8; in_inport_data = 32'd9; in_alu_op = 4'd8; in_alu_start = 1'b1; step();
      for (int k = 1; k <= 10; k++) begin
         idle();
         if (k == 10) in_clr_n = 1'b0;
         #1 chk("abort_busy_pre", out_alu_busy, 1);
         step();
      end
      idle();
      #1 chk("abort_busy", out_alu_busy, 0);
      step();
      rd(4'd4, 4'd0, "abort_zhi", 32'd0);
      rd(4'd5, 4'd0, "abort_zlo", 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         idle();
         #1 seen |= out_alu_done;
         step();
      end
      chk("abort_no_done", seen, 0);

      for (int n = 0; n < 3000; n++) begin
         in_clr_n         = ($urandom_range(0, 299) != 0);
         in_bus_src       = 4'($urandom_range(0, 15));
         in_reg_sel       = 4'($urandom);
         in_regfile_write = ($urandom_range(0, 3) == 0);
         in_hi_write      = ($urandom_range(0, 3) == 0);
         in_lo_write      = ($urandom_range(0, 3) == 0);
         in_y_write       = ($urandom_range(0, 3) == 0);
         in_ir_write      = ($urandom_range(0, 5) == 0);
         in_mar_write     = ($urandom_range(0, 3) == 0);
         in_pc_write      = ($urandom_range(0, 3) == 0);
         in_mdr_write     = ($urandom_range(0, 3) == 0);
         in_inc_pc        = $urandom_range(0, 1) == 1;
         in_mdr_select    = $urandom_range(0, 1) == 1;
         in_alu_start     = ($urandom_range(0, 3) == 0);
         in_alu_op        = ($urandom_range(0, 2) == 0) ? 4'(8 + $urandom_range(0, 1))
                                                         : 4'($urandom_range(0, 15));
         in_mem_data      = $urandom;
         in_inport_data   = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
